// File: rtl/r_format_decode.sv
// rtl/r_format_decode.sv - R-format decode and operand fetch with 32x32 register file and one-entry issue register
module r_format_decode #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_input,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [31:0]           instr,
   input  logic                  wb_enable,
   input  logic [4:0]            wb_address,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  issue_valid,
   input  logic                  issue_ready,
   output logic [2:0]            ALU_operation,
   output logic [4:0]            rs_address,
   output logic [4:0]            rt_address,
   output logic [4:0]            out_address,
   output logic [DATA_WIDTH-1:0] rs_data,
   output logic [DATA_WIDTH-1:0] rt_data,
   output logic                  write_enabled,
   output logic                  illegal_instr
);

   // Instruction fields
   logic [5:0] opcode;
   logic [4:0] rs_f;
   logic [4:0] rt_f;
   logic [4:0] rd_f;
   logic [5:0] funct;

   assign opcode = instr[31:26];
   assign rs_f   = instr[25:21];
   assign rt_f   = instr[20:16];
   assign rd_f   = instr[15:11];
   assign funct  = instr[5:0];

   // Register file; entry 0 is never written so it always reads zero
   logic [DATA_WIDTH-1:0] rf_q [32];

   // Issue register state
   logic                  issue_valid_q, issue_valid_d;
   logic [2:0]            alu_op_q, alu_op_d;
   logic [4:0]            rs_addr_q, rs_addr_d;
   logic [4:0]            rt_addr_q, rt_addr_d;
   logic [4:0]            rd_addr_q, rd_addr_d;
   logic [DATA_WIDTH-1:0] rs_data_q, rs_data_d;
   logic [DATA_WIDTH-1:0] rt_data_q, rt_data_d;
   logic                  wr_en_q, wr_en_d;
   logic                  illegal_q, illegal_d;

   logic                  wb_hit;
   logic                  accept;
   logic                  legal;
   logic [2:0]            alu_dec;
   logic [DATA_WIDTH-1:0] rs_read;
   logic [DATA_WIDTH-1:0] rt_read;

   // A write to r0 is a no-op everywhere, including bypass and refresh
   assign wb_hit      = wb_enable && (wb_address != 5'd0);
   assign instr_ready = !issue_valid_q || issue_ready;
   assign accept      = instr_valid && instr_ready;

   // funct decode; anything not listed, or a nonzero opcode, is illegal
   always_comb begin
      legal   = 1'b0;
      alu_dec = 3'b000;
      if (opcode == 6'd0) begin
         case (funct)
            6'h20: begin legal = 1'b1; alu_dec = 3'b010; end
            6'h22: begin legal = 1'b1; alu_dec = 3'b110; end
            6'h24: begin legal = 1'b1; alu_dec = 3'b000; end
            6'h25: begin legal = 1'b1; alu_dec = 3'b001; end
            6'h2A: begin legal = 1'b1; alu_dec = 3'b111; end
            default: begin legal = 1'b0; alu_dec = 3'b000; end
         endcase
      end
   end

   // Operand read with write-through bypass so a same-edge write-back is not missed
   always_comb begin
      rs_read = rf_q[rs_f];
      rt_read = rf_q[rt_f];
      if (wb_hit && (wb_address == rs_f)) rs_read = wb_data;
      if (wb_hit && (wb_address == rt_f)) rt_read = wb_data;
   end

   // Next state of the issue register: load on accept, clear on consume, else hold with operand refresh
   always_comb begin
      issue_valid_d = issue_valid_q;
      alu_op_d      = alu_op_q;
      rs_addr_d     = rs_addr_q;
      rt_addr_d     = rt_addr_q;
      rd_addr_d     = rd_addr_q;
      rs_data_d     = rs_data_q;
      rt_data_d     = rt_data_q;
      wr_en_d       = wr_en_q;
      illegal_d     = illegal_q;
      if (accept) begin
         issue_valid_d = 1'b1;
         alu_op_d      = alu_dec;
         rs_addr_d     = rs_f;
         rt_addr_d     = rt_f;
         rd_addr_d     = rd_f;
         rs_data_d     = rs_read;
         rt_data_d     = rt_read;
         wr_en_d       = legal && (rd_f != 5'd0);
         illegal_d     = !legal;
      end else if (issue_valid_q && issue_ready) begin
         issue_valid_d = 1'b0;
      end else if (issue_valid_q) begin
         if (wb_hit && (wb_address == rs_addr_q)) rs_data_d = wb_data;
         if (wb_hit && (wb_address == rt_addr_q)) rt_data_d = wb_data;
      end
   end

   // Register file write-back; reset clears every entry
   always_ff @(posedge clk or posedge reset_input) begin
      if (reset_input) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (wb_hit) begin
         rf_q[wb_address] <= wb_data;
      end
   end

   // Issue register; reset discards any held instruction
   always_ff @(posedge clk or posedge reset_input) begin
      if (reset_input) begin
         issue_valid_q <= 1'b0;
         alu_op_q      <= 3'b000;
         rs_addr_q     <= 5'd0;
         rt_addr_q     <= 5'd0;
         rd_addr_q     <= 5'd0;
         rs_data_q     <= '0;
         rt_data_q     <= '0;
         wr_en_q       <= 1'b0;
         illegal_q     <= 1'b0;
      end else begin
         issue_valid_q <= issue_valid_d;
         alu_op_q      <= alu_op_d;
         rs_addr_q     <= rs_addr_d;
         rt_addr_q     <= rt_addr_d;
         rd_addr_q     <= rd_addr_d;
         rs_data_q     <= rs_data_d;
         rt_data_q     <= rt_data_d;
         wr_en_q       <= wr_en_d;
         illegal_q     <= illegal_d;
      end
   end

   assign issue_valid   = issue_valid_q;
   assign ALU_operation = alu_op_q;
   assign rs_address    = rs_addr_q;
   assign rt_address    = rt_addr_q;
   assign out_address   = rd_addr_q;
   assign rs_data       = rs_data_q;
   assign rt_data       = rt_data_q;
   assign write_enabled = wr_en_q;
   assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_r_format_decode.sv
// tb/tb_r_format_decode.sv - directed scoreboard bench for r_format_decode
module tb_r_format_decode;

   logic        clk = 1'b0;
   logic        reset_input = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0;
   logic        wb_enable = 1'b0;
   logic [4:0]  wb_address = '0;
   logic [31:0] wb_data = '0;
   logic        issue_valid;
   logic        issue_ready = 1'b0;
   logic [2:0]  ALU_operation;
   logic [4:0]  rs_address, rt_address, out_address;
   logic [31:0] rs_data, rt_data;
   logic        write_enabled, illegal_instr;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]  alu;
      logic [4:0]  rs_a, rt_a, rd_a;
      logic [31:0] rs_d, rt_d;
      logic        we, ill;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_rf [32];
   logic        m_valid = 1'b0;

   r_format_decode #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset_input(reset_input),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .wb_enable(wb_enable), .wb_address(wb_address), .wb_data(wb_data),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .ALU_operation(ALU_operation), .rs_address(rs_address), .rt_address(rt_address),
      .out_address(out_address), .rs_data(rs_data), .rt_data(rt_data),
      .write_enabled(write_enabled), .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t predict(input logic [31:0] ins);
      exp_t e;
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      e.rs_a = ins[25:21];
      e.rt_a = ins[20:16];
      e.rd_a = ins[15:11];
      e.rs_d = (e.rs_a == 5'd0) ? 32'd0 : model_rf[e.rs_a];
      e.rt_d = (e.rt_a == 5'd0) ? 32'd0 : model_rf[e.rt_a];
      if (wb_enable && wb_address != 5'd0 && wb_address == e.rs_a) e.rs_d = wb_data;
      if (wb_enable && wb_address != 5'd0 && wb_address == e.rt_a) e.rt_d = wb_data;
      e.ill = 1'b0;
      if (op != 6'd0) e.ill = 1'b1;
      else if (fn == 6'h20) e.alu = 3'b010;
      else if (fn == 6'h22) e.alu = 3'b110;
      else if (fn == 6'h24) e.alu = 3'b000;
      else if (fn == 6'h25) e.alu = 3'b001;
      else if (fn == 6'h2A) e.alu = 3'b111;
      else e.ill = 1'b1;
      if (e.ill) e.alu = 3'b000;
      e.we = !e.ill && (e.rd_a != 5'd0);
      return e;
   endfunction

   task automatic cmp_held(input exp_t e);
      chk("alu", 32'(ALU_operation), 32'(e.alu));
      chk("rs_addr", 32'(rs_address), 32'(e.rs_a));
      chk("rt_addr", 32'(rt_address), 32'(e.rt_a));
      chk("rd_addr", 32'(out_address), 32'(e.rd_a));
      chk("rs_data", rs_data, e.rs_d);
      chk("rt_data", rt_data, e.rt_d);
      chk("write_en", 32'(write_enabled), 32'(e.we));
      chk("illegal", 32'(illegal_instr), 32'(e.ill));
   endtask

   // one clock: drive inputs, compare against model, advance the model across the edge
   task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
      logic acc;
      instr_valid = v; instr = ins; issue_ready = rdy;
      wb_enable = we; wb_address = wa; wb_data = wd;
      #1;
      chk("issue_valid", 32'(issue_valid), 32'(m_valid));
      chk("instr_ready", 32'(instr_ready), 32'(!m_valid || rdy));
      acc = v && (!m_valid || rdy);
      if (m_valid) cmp_held(sb[0]);
      if (m_valid && rdy) void'(sb.pop_front());
      if (acc) sb.push_back(predict(ins));
      else if (m_valid && !rdy && we && wa != 5'd0) begin
         if (sb[0].rs_a == wa) sb[0].rs_d = wd;
         if (sb[0].rt_a == wa) sb[0].rt_d = wd;
      end
      if (we && wa != 5'd0) model_rf[wa] = wd;
      m_valid = acc || (m_valid && !rdy);
      @(posedge clk); #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      sb.delete();
      m_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      // reset state
      reset_input = 1'b1;
      @(posedge clk); #1;
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_instr_ready", 32'(instr_ready), 32'd1);
      chk("rst_alu", 32'(ALU_operation), 32'd0);
      chk("rst_rs_data", rs_data, 32'd0);
      chk("rst_write_en", 32'(write_enabled), 32'd0);
      chk("rst_illegal", 32'(illegal_instr), 32'd0);
      reset_input = 1'b0;
      @(posedge clk); #1;

      // write back r1=5, r2=7, then ADD r5,r1,r2
      cycle(0, 32'h0, 1, 1, 5'd1, 32'd5);
      cycle(0, 32'h0, 1, 1, 5'd2, 32'd7);
      cycle(1, 32'h00222820, 0, 0, 5'd0, 32'd0);
      chk("add_valid", 32'(issue_valid), 32'd1);
      chk("add_alu", 32'(ALU_operation), 32'b010);
      chk("add_rs", rs_data, 32'd5);
      chk("add_rt", rt_data, 32'd7);
      chk("add_rd", 32'(out_address), 32'd5);
      chk("add_we", 32'(write_enabled), 32'd1);

      // SUB r6,r3,r0 with same-cycle write-back to r3 (bypass), back-to-back with ADD consume
      cycle(1, 32'h00603022, 1, 1, 5'd3, 32'hDEADBEEF);
      chk("sub_bypass", rs_data, 32'hDEADBEEF);
      chk("sub_alu", 32'(ALU_operation), 32'b110);

      // AND r7,r1,r2 then stall three cycles with OR waiting; r2=9 during stall refreshes held rt
      cycle(1, 32'h00223824, 1, 0, 5'd0, 32'd0);
      cycle(1, 32'h00414025, 0, 1, 5'd2, 32'd9);
      chk("stall_ready", 32'(instr_ready), 32'd0);
      chk("refresh_rt", rt_data, 32'd9);
      cycle(1, 32'h00414025, 0, 0, 5'd0, 32'd0);
      cycle(1, 32'h00414025, 0, 0, 5'd0, 32'd0);
      chk("frozen_alu", 32'(ALU_operation), 32'b000);
      cycle(1, 32'h00414025, 1, 0, 5'd0, 32'd0);
      chk("or_alu", 32'(ALU_operation), 32'b001);
      chk("or_rs", rs_data, 32'd9);

      // rd=0 instruction, then write to r0, then read r0 with a same-cycle r0 write
      cycle(1, 32'h00010020, 1, 0, 5'd0, 32'd0);
      chk("rd0_we", 32'(write_enabled), 32'd0);
      cycle(0, 32'h0, 1, 1, 5'd0, 32'h1234);
      cycle(1, 32'h00004820, 1, 1, 5'd0, 32'h1234);
      chk("r0_read", rs_data, 32'd0);

      // illegal opcode 0x08 and illegal funct 0x27 (SLT issued in between)
      cycle(1, 32'h20225020, 1, 0, 5'd0, 32'd0);
      chk("ill_op", 32'(illegal_instr), 32'd1);
      chk("ill_op_we", 32'(write_enabled), 32'd0);
      cycle(1, 32'h0022602A, 1, 0, 5'd0, 32'd0);
      chk("slt_alu", 32'(ALU_operation), 32'b111);
      cycle(1, 32'h00225827, 1, 0, 5'd0, 32'd0);
      chk("ill_fn", 32'(illegal_instr), 32'd1);
      chk("ill_fn_alu", 32'(ALU_operation), 32'b000);

      // reset mid-stall with r4=0x55
      cycle(0, 32'h0, 1, 1, 5'd4, 32'h55);
      cycle(1, 32'h00806020, 0, 0, 5'd0, 32'd0);
      cycle(0, 32'h0, 0, 0, 5'd0, 32'd0);
      reset_input = 1'b1;
      #1;
      chk("async_rst_valid", 32'(issue_valid), 32'd0);
      chk("async_rst_ready", 32'(instr_ready), 32'd1);
      model_reset();
      @(posedge clk); #1;
      reset_input = 1'b0;
      cycle(1, 32'h00806020, 0, 0, 5'd0, 32'd0);
      chk("r4_cleared", rs_data, 32'd0);
      cycle(0, 32'h0, 1, 0, 5'd0, 32'd0);
      cycle(0, 32'h0, 1, 0, 5'd0, 32'd0);
      chk("drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/r_format_decode.md
# r_format_decode

Decode/operand-fetch stage directly upstream of the R-format execute/write stage. Accepts a 32-bit MIPS R-format instruction word and decodes `funct` into the 3-bit ALU operation. Reads `rs`/`rt` from an internal 32x32 register file and presents operands, addresses and write enable to the execute stage through a one-entry valid/ready output register. The execute stage's result returns through the write-back port into the same register file.

## Interface
- `DATA_WIDTH`, 32, register and operand width (only 32 supported)
- `clk` input 1, single clock, all state on rising edge
- `reset_input` input 1, asynchronous, active-high reset
- `instr_valid` input 1, upstream has an instruction on `instr`
- `instr_ready` output 1, stage can accept this cycle
- `instr` input 32, instruction word: `[31:26]` opcode, `[25:21]` rs, `[20:16]` rt, `[15:11]` rd, `[10:6]` shamt, `[5:0]` funct
- `wb_enable` input 1, write `wb_data` to `wb_address` this edge
- `wb_address` input 5, write-back register index
- `wb_data` input 32, write-back value
- `issue_valid` output 1, output register holds a decoded instruction
- `issue_ready` input 1, execute stage consumes this cycle
- `ALU_operation` output 3, ALU opcode for execute
- `rs_address`, `rt_address`, `out_address` output 5 each, rs, rt, rd fields
- `rs_data`, `rt_data` output 32 each, operand values
- `write_enabled` output 1, execute stage shall write its result
- `illegal_instr` output 1, held instruction is not a supported R-format instruction

## Operation
- Register file: 32 entries x 32 bits.
  - Entry 0 reads 0 always; writes to it are dropped.
  - A write occurs on a rising edge when `wb_enable=1` and `wb_address!=0`.
- Decode (opcode must be 0):
  - funct 0x20 ADD -> 3'b010
  - funct 0x22 SUB -> 3'b110
  - funct 0x24 AND -> 3'b000
  - funct 0x25 OR -> 3'b001
  - funct 0x2A SLT -> 3'b111
- Any other opcode or funct is illegal:
  - `illegal_instr=1`, `ALU_operation=3'b000`, `write_enabled=0`.
  - Address fields and operands are still issued.
  - shamt is ignored.
- `write_enabled` = legal AND rd!=0.
- Operand read at accept, with write-through bypass: if `wb_enable=1`, `wb_address!=0` and `wb_address` equals rs (or rt), the captured operand is `wb_data`, not the stale entry.
- Held-entry refresh: while `issue_valid=1` and not consumed, a write-back matching held `rs_address`/`rt_address` (nonzero) updates the held `rs_data`/`rt_data` on the same edge.
- Handshake:
  - `instr_ready = !issue_valid || issue_ready` (combinational).
  - Accept when `instr_valid && instr_ready`.
  - Output register loads on the accept edge and `issue_valid` becomes 1.
  - Consume without a new accept: `issue_valid` drops to 0.
  - Consume and accept in the same cycle: back-to-back, `issue_valid` stays 1.
- Outputs are stable while `issue_valid=1 && issue_ready=0`, except for the held-entry refresh of operands.

## Timing
- Latency: accept at edge N -> `issue_valid=1` and all issue fields valid after edge N; throughput 1 instruction/cycle.
- Reset (asynchronous, immediate on `reset_input=1`):
  - All 32 register entries cleared to 0.
  - `issue_valid`, `illegal_instr`, `write_enabled` = 0.
  - `ALU_operation`, all addresses, all data = 0.
  - `instr_ready=1` once `issue_valid=0`.
- While `reset_input=1`: no accept and no write-back; in-flight held instruction is discarded.
- Simultaneous write-back and accept to the same register: the new value is captured (bypass).
- Simultaneous write-back, held-entry refresh and consume: the refresh is irrelevant because a new load or clear wins.
- `wb_address=0` with `wb_enable=1`: no effect anywhere, including bypass.

## Test plan
- Reset, write back r1=5 and r2=7, then issue ADD rd=5, rs=1, rt=2 (0x00222820) -> one cycle later `issue_valid=1`, `ALU_operation=010`, `rs_data=5`, `rt_data=7`, `out_address=5`, `write_enabled=1`.
- Issue SUB with rs=3 while `wb_enable=1`, `wb_address=3`, `wb_data=0xDEADBEEF` in the same cycle -> `rs_data=0xDEADBEEF`.
- Hold `issue_ready=0` for 3 cycles with a valid instruction waiting -> `instr_ready=0`, outputs frozen.
  - Write back r2=9 during the stall -> held `rt_data=9`.
  - Then raise `issue_ready` -> next instruction accepted on the same edge.
- Issue instruction with rd=0, then write back `wb_address=0`, `wb_data=0x1234` -> `write_enabled=0`; a later read of r0 gives `rs_data=0`.
- Issue opcode 0x08 and, separately, funct 0x27 -> `illegal_instr=1`, `write_enabled=0`, `ALU_operation=000`.
- Assert `reset_input` mid-stall with r4=0x55 -> `issue_valid=0` immediately; after release, reading r4 gives 0.
